// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic datapath: default widths, LFSR taps and FSM states.
package sc_pkg;

  localparam int unsigned ScLength = 4;
  localparam int unsigned ScN      = 1 << ScLength;
  localparam int unsigned ScSeed   = 1;

  // Fibonacci tap mask (bit i set = r[i] feeds the XOR) for a maximal-length left-shift LFSR.
  function automatic logic [31:0] sc_tap_mask(input int unsigned len);
    logic [31:0] mask;
    case (len)
      3:       mask = 32'h0000_0006;  // x^3+x^2+1
      4:       mask = 32'h0000_000C;  // x^4+x^3+1
      5:       mask = 32'h0000_0014;  // x^5+x^3+1
      6:       mask = 32'h0000_0030;  // x^6+x^5+1
      7:       mask = 32'h0000_0060;  // x^7+x^6+1
      8:       mask = 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sc_state_e;

endpackage

// File: rtl/stochastic_number_generator_if.sv
// Load request and stream outputs of the binary-to-stochastic converter.
interface stochastic_number_generator_if
  import sc_pkg::*;
#(
  parameter int unsigned LENGTH = ScLength
) ();

  logic                     load;
  logic [LENGTH-1:0]        Bnum;
  logic                     busy;
  logic                     sc_bit;
  logic                     sc_valid;
  logic [(1 << LENGTH)-1:0] SCnum;
  logic                     done;

  modport master (
    output load,
    output Bnum,
    input  busy,
    input  sc_bit,
    input  sc_valid,
    input  SCnum,
    input  done
  );

  modport slave (
    input  load,
    input  Bnum,
    output busy,
    output sc_bit,
    output sc_valid,
    output SCnum,
    output done
  );

endinterface

// File: rtl/sc_debruijn_lfsr.sv
// De Bruijn sequence generator: maximal-length LFSR with the all-zero state spliced in.
module sc_debruijn_lfsr
  import sc_pkg::*;
#(
  parameter int unsigned       LENGTH = ScLength,
  parameter logic [LENGTH-1:0] SEED   = LENGTH'(ScSeed)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              en,
  output logic [LENGTH-1:0] r
);

  localparam logic [LENGTH-1:0] Taps = LENGTH'(sc_tap_mask(LENGTH));

  logic [LENGTH-1:0] r_q, r_d;
  logic              fb;

  // Next state: reload the seed or step once; the zero test splices 0..0 in after 10..0.
  always_comb begin
    fb  = (^(r_q & Taps)) ^ (r_q[LENGTH-2:0] == '0);
    r_d = r_q;
    if (init) begin
      r_d = SEED;
    end else if (en) begin
      r_d = {r_q[LENGTH-2:0], fb};
    end
  end

  // Sequence state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SEED;
    end else begin
      r_q <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: rtl/stochastic_number_generator.sv
// Binary-to-stochastic converter: emits 2**LENGTH bits, (r_k < value) per bit, serially and
// assembled into a parallel vector.
module stochastic_number_generator
  import sc_pkg::*;
#(
  parameter int unsigned       LENGTH = ScLength,
  parameter logic [LENGTH-1:0] SEED   = LENGTH'(ScSeed)
) (
  input logic                          clk,
  input logic                          rst,
  stochastic_number_generator_if.slave bus
);

  localparam int unsigned       NumBits = 1 << LENGTH;
  localparam logic [LENGTH-1:0] KLast   = LENGTH'(NumBits - 1);

  sc_state_e          state_q, state_d;
  logic [LENGTH-1:0]  value_q, value_d;
  logic [LENGTH-1:0]  k_q, k_d;
  logic [NumBits-1:0] scnum_q, scnum_d;
  logic               sc_bit_q, sc_bit_d;
  logic               sc_valid_q, sc_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LENGTH-1:0]  r;
  logic               accept;
  logic               stream_bit;

  // Loads are only honoured in idle; anything seen in run or done is dropped.
  assign accept     = (state_q == StIdle) && bus.load;
  assign stream_bit = (r < value_q);

  sc_debruijn_lfsr #(
    .LENGTH (LENGTH),
    .SEED   (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .init (accept),
    .en   (state_q == StRun),
    .r    (r)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one pass of NumBits bits, then a single done cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.load) state_d = StRun;
      StRun:   if (k_q == KLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, computed one cycle ahead so that every port is driven from a flop.
  always_comb begin
    sc_bit_d   = 1'b0;
    sc_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StRun: begin
        sc_bit_d   = stream_bit;
        sc_valid_d = 1'b1;
        busy_d     = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state: capture on accept, then fill SCnum one index per run cycle.
  always_comb begin
    value_d = value_q;
    k_d     = k_q;
    scnum_d = scnum_q;
    if (accept) begin
      value_d = bus.Bnum;
      k_d     = '0;
      scnum_d = '0;
    end else if (state_q == StRun) begin
      scnum_d[k_q] = stream_bit;
      k_d          = k_q + 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      k_q        <= '0;
      scnum_q    <= '0;
      sc_bit_q   <= 1'b0;
      sc_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      value_q    <= value_d;
      k_q        <= k_d;
      scnum_q    <= scnum_d;
      sc_bit_q   <= sc_bit_d;
      sc_valid_q <= sc_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.sc_bit   = sc_bit_q;
  assign bus.sc_valid = sc_valid_q;
  assign bus.SCnum    = scnum_q;
  assign bus.done     = done_q;

endmodule

// File: doc/stochastic_number_generator.md
# stochastic_number_generator

Binary-to-stochastic converter: accepts an unsigned LENGTH-bit value and emits a unipolar stochastic bitstream of exactly 2**LENGTH bits whose count of ones equals that value. The stream is delivered serially, one bit per cycle. It is also assembled into a parallel 2**LENGTH-bit vector. This block is the producer side of the stochastic datapath: its parallel output feeds the stochastic arithmetic units and the stochastic-to-binary reconversion block.

## Interface
- LENGTH, 4: binary width; stream length N = 2**LENGTH.
- SEED, 4'b0001: nonzero LFSR start state, reloaded on every accepted load.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  request to start a conversion; sampled on clk.
- Bnum  input  LENGTH  unsigned value to convert; captured when load is accepted.
- busy  output  1  high while a stream is being generated.
- sc_bit  output  1  current serial stream bit; meaningful only while sc_valid.
- sc_valid  output  1  qualifies sc_bit.
- SCnum  output  N  assembled stream; bit k is stream bit k.
- done  output  1  one-cycle pulse; SCnum is complete and stable.

## Operation
- Random source: LENGTH-bit de Bruijn sequence, i.e. a maximal-length Fibonacci LFSR extended with the all-zero state.
  - Visits all N values exactly once per N steps.
  - For LENGTH=4: polynomial x^4+x^3+1, shifting left, feedback = r[3]^r[2].
  - The extension XORs the feedback with (r[2:0]==0), which inserts 0000 after 1000.
- Comparator: stream bit k = (r_k < value_q), unsigned LENGTH-bit compare. r_0 = SEED.
- Result: popcount(SCnum) == value_q exactly, for any value_q in 0..N-1. All-ones cannot be represented; value N-1 yields exactly one zero.
- FSM states:
  - IDLE: load → capture Bnum into value_q, set r=SEED, k=0, clear SCnum → RUN.
  - RUN: each cycle, drive sc_bit and sc_valid, write SCnum[k], advance r, increment k. When k==N-1 → DONE.
  - DONE: done=1 for one cycle → IDLE. A load present in DONE is ignored; load must be re-presented in IDLE.
- load while RUN or DONE is ignored; it does not queue.
- Bnum changes after capture have no effect.
- SCnum holds its last complete value until the next accepted load, which clears it.
- Counter k is LENGTH bits wide. Terminal detection is k==N-1, with no wrap to a second pass.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, busy=0, sc_bit=0, sc_valid=0, SCnum=0, done=0, r=SEED, k=0, value_q=0.
- Cycle 0: load sampled high in IDLE.
- Cycles 1..N: sc_valid=1, sc_bit = stream bit (cycle−1), busy=1. All outputs are registered.
- Cycle N+1: done=1, busy=0, sc_valid=0. SCnum fully valid from this cycle.
- Cycle N+2: IDLE. Earliest next accepted load is sampled here.
- Throughput: one conversion per N+2 cycles.
- Reset asserted mid-RUN aborts the stream. All outputs return to reset values, and no done pulse follows.

## Structure
- Shared package sc_pkg holds:
  - LENGTH default.
  - Derived N.
  - The LFSR tap mask per LENGTH.
  - Default SEED.
  - State enum (IDLE, RUN, DONE).
  - These are shared with the reconversion block and the arithmetic units.
- One sub-module, sc_debruijn_lfsr (ports: clk, rst, init, en, r), holds the sequence generator.
- The top level contains the FSM, the comparator and the SCnum assembly register.

## Test plan
- Bnum=0, load → 16 cycles of sc_bit=0; done at cycle 17; SCnum=16'h0000.
- Bnum=15 → popcount(SCnum)=15; the single zero sits at the index k where r_k=15.
- Bnum=8, SEED=1 → popcount=8. The serial sc_bit sequence must match SCnum bit-for-bit, and match a reference-model de Bruijn sequence.
- Sweep Bnum 0..15, back-to-back: load re-asserted in IDLE each time → popcount==Bnum every time; load held high during RUN/DONE is ignored; period is 18 cycles.
- Assert rst at cycle 7 of a Bnum=10 run → all outputs 0 immediately and no done pulse. A subsequent load of Bnum=10 produces SCnum identical to an uninterrupted run.
- Change Bnum from 3 to 12 at cycle 4 of a run → the stream still has popcount 3.
